// File: rtl/issue_scoreboard.sv
// Issue-stage hazard controller: tracks outstanding load write-backs and gates decode->execute flow control.
// Optional stall-cycle counter built only when ISSUE_SCOREBOARD_STALL_CNT_EN is defined.
`ifndef ZONE_RANGE
`define ZONE_RANGE 1:0
`endif
`ifndef ZONE_LOADQ
`define ZONE_LOADQ 2'd1
`endif

module issue_scoreboard #(
   parameter int C_LOADQ_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              resetb_i,
   input  logic              flush_i,
   input  logic              ids_valid_i,
   output logic              ids_ready_o,
   input  logic              ins_err_i,
   input  logic [4:0]        regd_addr_i,
   input  logic              regs1_rd_i,
   input  logic [4:0]        regs1_addr_i,
   input  logic              regs2_rd_i,
   input  logic [4:0]        regs2_addr_i,
   input  logic [`ZONE_RANGE] zone_i,
   input  logic              csr_rd_i,
   input  logic              csr_wr_i,
   output logic              exs_valid_o,
   input  logic              exs_ready_i,
   input  logic              serial_done_i,
   input  logic              lq_wb_valid_i,
   input  logic [4:0]        lq_wb_addr_i,
   output logic [31:0]       stall_cnt_o
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SERIAL} state_t;

   localparam logic [3:0] DEPTH = 4'(C_LOADQ_DEPTH);

   state_t      state, state_next;
   logic [31:0] sb, sb_eff, wb_mask, set_mask;
   logic [3:0]  cnt, cnt_eff;
   logic        is_load, serial, wb_hit, hazard, issue_ok, fire, set_hit;

   assign is_load = (zone_i == `ZONE_LOADQ) & ~ins_err_i;
   assign serial  = csr_rd_i | csr_wr_i | ins_err_i;

   // sb[0] is never set, so write-backs to x0 or idle registers never hit
   assign wb_hit  = lq_wb_valid_i & sb[lq_wb_addr_i];
   assign wb_mask = wb_hit ? (32'd1 << lq_wb_addr_i) : 32'd0;
   assign sb_eff  = sb & ~wb_mask;
   assign cnt_eff = cnt - {3'd0, wb_hit};

   assign hazard = (regs1_rd_i & sb_eff[regs1_addr_i])
                 | (regs2_rd_i & sb_eff[regs2_addr_i])
                 | (is_load & sb_eff[regd_addr_i])
                 | (is_load & (cnt_eff == DEPTH));

   assign issue_ok = ids_valid_i & ~hazard & ~flush_i;

   always_comb begin
      state_next  = state;
      exs_valid_o = 1'b0;
      ids_ready_o = 1'b0;
      if (resetb_i) begin
         case (state)
            S_RUN: begin
               if (ids_valid_i & serial & (cnt_eff != 4'd0)) begin
                  ids_ready_o = flush_i;
                  state_next  = S_DRAIN;
               end else begin
                  exs_valid_o = issue_ok;
                  ids_ready_o = (exs_ready_i & ~hazard) | flush_i;
                  if (ids_valid_i & serial & issue_ok & exs_ready_i)
                     state_next = S_SERIAL;
               end
            end
            S_DRAIN: begin
               ids_ready_o = flush_i;
               if (cnt_eff == 4'd0) state_next = S_RUN;
            end
            S_SERIAL: begin
               ids_ready_o = flush_i;
               if (serial_done_i) state_next = S_RUN;
            end
            default: state_next = S_RUN;
         endcase
         if (flush_i) state_next = S_RUN;
      end
   end

   // loads with rd == x0 never write back, so they are not tracked
   assign fire     = exs_valid_o & exs_ready_i;
   assign set_hit  = fire & is_load & (regd_addr_i != 5'd0);
   assign set_mask = set_hit ? (32'd1 << regd_addr_i) : 32'd0;

   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state <= S_RUN;
         sb    <= 32'd0;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         sb    <= sb_eff | set_mask;
         cnt   <= cnt_eff + {3'd0, set_hit};
      end
   end

`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i)
         stall_cnt <= 32'd0;
      else if (ids_valid_i & ~ids_ready_o & ~flush_i)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: expected {exs_valid, ids_ready} pairs are queued
// as stimulus is driven and popped when the DUT outputs are sampled mid-cycle.
`ifndef ZONE_RANGE
`define ZONE_RANGE 1:0
`endif
`ifndef ZONE_LOADQ
`define ZONE_LOADQ 2'd1
`endif

module tb_issue_scoreboard;

   logic              clk_i = 1'b0;
   logic              resetb_i, flush_i, ids_valid_i, ins_err_i;
   logic              regs1_rd_i, regs2_rd_i, csr_rd_i, csr_wr_i;
   logic              exs_ready_i, serial_done_i, lq_wb_valid_i;
   logic [4:0]        regd_addr_i, regs1_addr_i, regs2_addr_i, lq_wb_addr_i;
   logic [`ZONE_RANGE] zone_i;
   logic              ids_ready_o, exs_valid_o;
   logic [31:0]       stall_cnt_o;

   int checks = 0;
   int passes = 0;
   logic [1:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   issue_scoreboard #(.C_LOADQ_DEPTH(4)) dut (
      .clk_i(clk_i), .resetb_i(resetb_i), .flush_i(flush_i),
      .ids_valid_i(ids_valid_i), .ids_ready_o(ids_ready_o), .ins_err_i(ins_err_i),
      .regd_addr_i(regd_addr_i), .regs1_rd_i(regs1_rd_i), .regs1_addr_i(regs1_addr_i),
      .regs2_rd_i(regs2_rd_i), .regs2_addr_i(regs2_addr_i), .zone_i(zone_i),
      .csr_rd_i(csr_rd_i), .csr_wr_i(csr_wr_i), .exs_valid_o(exs_valid_o),
      .exs_ready_i(exs_ready_i), .serial_done_i(serial_done_i),
      .lq_wb_valid_i(lq_wb_valid_i), .lq_wb_addr_i(lq_wb_addr_i), .stall_cnt_o(stall_cnt_o)
   );

   task automatic idle();
      ids_valid_i = 0; ins_err_i = 0; regd_addr_i = 0;
      regs1_rd_i = 0; regs1_addr_i = 0; regs2_rd_i = 0; regs2_addr_i = 0;
      zone_i = '0; csr_rd_i = 0; csr_wr_i = 0; flush_i = 0;
      exs_ready_i = 1; serial_done_i = 0; lq_wb_valid_i = 0; lq_wb_addr_i = 0;
   endtask

   task automatic set_ins(input logic v, input logic [4:0] rd, input logic s1, input logic [4:0] a1,
                          input logic s2, input logic [4:0] a2, input logic ld, input logic csr);
      ids_valid_i = v; regd_addr_i = rd;
      regs1_rd_i = s1; regs1_addr_i = a1; regs2_rd_i = s2; regs2_addr_i = a2;
      zone_i = ld ? `ZONE_LOADQ : '0;
      csr_wr_i = csr;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] a);
      lq_wb_valid_i = v; lq_wb_addr_i = a;
   endtask

   task automatic test_reset();
      logic [1:0] e;
      idle();
      resetb_i = 0;
      ids_valid_i = 1;
      exp_q.push_back(2'b00);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if ({exs_valid_o, ids_ready_o} !== e)
         $display("FAIL reset_io valid/ready=%b expected %b", {exs_valid_o, ids_ready_o}, e);
      else passes++;
      checks++;
      if (stall_cnt_o !== 32'd0) $display("FAIL reset_stall_cnt got %0d expected 0", stall_cnt_o);
      else passes++;
      checks++;
      if (dut.cnt !== 4'd0 || dut.sb !== 32'd0)
         $display("FAIL reset_state cnt=%0d sb=%h expected 0/0", dut.cnt, dut.sb);
      else passes++;
      @(posedge clk_i); #1;
      resetb_i = 1;
      idle();
   endtask

   task automatic test_raw();
      logic [1:0] e;
      for (int c = 0; c < 4; c++) begin
         if (c == 0) set_ins(1, 5, 0, 0, 0, 0, 1, 0);
         else        set_ins(1, 6, 1, 5, 1, 1, 0, 0);
         set_wb(c == 3, 5);
         exp_q.push_back((c == 0 || c == 3) ? 2'b11 : 2'b00);
         @(negedge clk_i);
         e = exp_q.pop_front();
         checks++;
         if ({exs_valid_o, ids_ready_o} !== e)
            $display("FAIL raw c%0d valid/ready=%b expected %b", c, {exs_valid_o, ids_ready_o}, e);
         else passes++;
         if (c == 3) begin
            checks++;
            if (dut.cnt !== 4'd1) $display("FAIL raw_cnt_before got %0d expected 1", dut.cnt);
            else passes++;
         end
         @(posedge clk_i); #1;
      end
      idle();
      checks++;
      if (dut.cnt !== 4'd0) $display("FAIL raw_cnt_after got %0d expected 0", dut.cnt);
      else passes++;
   endtask

   task automatic test_loadq_full();
      logic [1:0] e;
      logic [4:0] rds [0:5];
      rds = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd7};
      for (int c = 0; c < 6; c++) begin
         set_ins(1, rds[c], 0, 0, 0, 0, 1, 0);
         set_wb(c == 5, 2);
         exp_q.push_back(c == 4 ? 2'b00 : 2'b11);
         @(negedge clk_i);
         e = exp_q.pop_front();
         checks++;
         if ({exs_valid_o, ids_ready_o} !== e)
            $display("FAIL full c%0d valid/ready=%b expected %b", c, {exs_valid_o, ids_ready_o}, e);
         else passes++;
         @(posedge clk_i); #1;
      end
      idle();
      checks++;
      if (dut.cnt !== 4'd4) $display("FAIL full_cnt got %0d expected 4", dut.cnt);
      else passes++;
      for (int c = 0; c < 4; c++) begin
         set_wb(1, c == 0 ? 5'd1 : c == 1 ? 5'd3 : c == 2 ? 5'd4 : 5'd7);
         @(posedge clk_i); #1;
      end
      idle();
      checks++;
      if (dut.cnt !== 4'd0 || dut.sb !== 32'd0)
         $display("FAIL full_drain cnt=%0d sb=%h expected 0/0", dut.cnt, dut.sb);
      else passes++;
   endtask

   task automatic test_serial();
      logic [1:0] e;
      logic [1:0] tab [0:8];
      tab = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
      for (int c = 0; c < 9; c++) begin
         idle();
         if (c == 0)      set_ins(1, 10, 0, 0, 0, 0, 1, 0);
         else if (c == 1) set_ins(1, 11, 0, 0, 0, 0, 1, 0);
         else if (c <= 5) set_ins(1, 3, 1, 1, 0, 0, 0, 1);
         else             set_ins(1, 6, 1, 1, 0, 0, 0, 0);
         if (c == 3) set_wb(1, 10);
         if (c == 4) set_wb(1, 11);
         serial_done_i = (c == 7);
         exp_q.push_back(tab[c]);
         @(negedge clk_i);
         e = exp_q.pop_front();
         checks++;
         if ({exs_valid_o, ids_ready_o} !== e)
            $display("FAIL serial c%0d valid/ready=%b expected %b", c, {exs_valid_o, ids_ready_o}, e);
         else passes++;
         @(posedge clk_i); #1;
      end
      idle();
      checks++;
      if (dut.cnt !== 4'd0) $display("FAIL serial_cnt got %0d expected 0", dut.cnt);
      else passes++;
   endtask

   task automatic test_x0_and_stray_wb();
      logic [1:0] e;
      logic [1:0] tab [0:2];
      tab = '{2'b11, 2'b01, 2'b11};
      for (int c = 0; c < 3; c++) begin
         idle();
         if (c == 0) set_ins(1, 0, 0, 0, 0, 0, 1, 0);
         if (c == 1) set_wb(1, 9);
         if (c == 2) set_ins(1, 6, 1, 9, 1, 0, 0, 0);
         exp_q.push_back(tab[c]);
         @(negedge clk_i);
         e = exp_q.pop_front();
         checks++;
         if ({exs_valid_o, ids_ready_o} !== e)
            $display("FAIL x0 c%0d valid/ready=%b expected %b", c, {exs_valid_o, ids_ready_o}, e);
         else passes++;
         @(posedge clk_i); #1;
      end
      idle();
      checks++;
      if (dut.cnt !== 4'd0 || dut.sb !== 32'd0)
         $display("FAIL x0_state cnt=%0d sb=%h expected 0/0", dut.cnt, dut.sb);
      else passes++;
   endtask

   task automatic test_flush();
      logic [1:0] e;
      logic [1:0] tab [0:7];
      tab = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11};
      for (int c = 0; c < 8; c++) begin
         idle();
         case (c)
            0:       set_ins(1, 5, 0, 0, 0, 0, 1, 0);
            1, 2:    set_ins(1, 3, 0, 0, 0, 0, 0, 1);
            3:       set_ins(1, 6, 1, 5, 0, 0, 0, 0);
            4:       begin set_ins(1, 3, 0, 0, 0, 0, 0, 1); set_wb(1, 5); end
            default: set_ins(1, 6, 1, 1, 0, 0, 0, 0);
         endcase
         flush_i = (c == 2 || c == 6);
         exp_q.push_back(tab[c]);
         @(negedge clk_i);
         e = exp_q.pop_front();
         checks++;
         if ({exs_valid_o, ids_ready_o} !== e)
            $display("FAIL flush c%0d valid/ready=%b expected %b", c, {exs_valid_o, ids_ready_o}, e);
         else passes++;
         if (c == 3) begin
            checks++;
            if (dut.sb[5] !== 1'b1 || dut.cnt !== 4'd1)
               $display("FAIL flush_keep sb5=%b cnt=%0d expected 1/1", dut.sb[5], dut.cnt);
            else passes++;
         end
         @(posedge clk_i); #1;
      end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [1:0] e;
      set_ins(1, 5, 0, 0, 0, 0, 1, 0);
      @(posedge clk_i); #1;
      idle();
      resetb_i = 0;
      #2;
      checks++;
      if (dut.cnt !== 4'd0 || dut.sb !== 32'd0)
         $display("FAIL reset_mid_clear cnt=%0d sb=%h expected 0/0", dut.cnt, dut.sb);
      else passes++;
      @(posedge clk_i); #1;
      resetb_i = 1;
      set_ins(1, 6, 1, 5, 0, 0, 0, 0);
      set_wb(1, 5);
      exp_q.push_back(2'b11);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if ({exs_valid_o, ids_ready_o} !== e)
         $display("FAIL reset_mid_issue valid/ready=%b expected %b", {exs_valid_o, ids_ready_o}, e);
      else passes++;
      @(posedge clk_i); #1;
      idle();
      checks++;
      if (dut.cnt !== 4'd0) $display("FAIL reset_mid_cnt got %0d expected 0", dut.cnt);
      else passes++;
   endtask

   task automatic test_stall_cnt();
      logic [1:0] e;
      logic [1:0] tab [0:5];
      logic [31:0] exp_stall;
      tab = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
      exp_stall = 32'd3;
`else
      exp_stall = 32'd0;
`endif
      idle();
      resetb_i = 0;
      #2;
      resetb_i = 1;
      @(posedge clk_i); #1;
      for (int c = 0; c < 6; c++) begin
         idle();
         if (c == 0) set_ins(1, 5, 0, 0, 0, 0, 1, 0);
         else        set_ins(1, 6, 1, 5, 0, 0, 0, 0);
         flush_i = (c == 4);
         set_wb(c == 5, 5);
         exp_q.push_back(tab[c]);
         @(negedge clk_i);
         e = exp_q.pop_front();
         checks++;
         if ({exs_valid_o, ids_ready_o} !== e)
            $display("FAIL stall c%0d valid/ready=%b expected %b", c, {exs_valid_o, ids_ready_o}, e);
         else passes++;
         @(posedge clk_i); #1;
      end
      idle();
      @(negedge clk_i);
      checks++;
      if (stall_cnt_o !== exp_stall)
         $display("FAIL stall_cnt got %0d expected %0d", stall_cnt_o, exp_stall);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_raw();
      test_loadq_full();
      test_serial();
      test_x0_and_stray_wb();
      test_flush();
      test_reset_mid();
      test_stall_cnt();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
